// File: rtl/dm_arb_pkg.sv
// Shared types and default sizing for the data-memory dump arbiter.
// The state encoding here is shared by the top-level FSM and by anything that decodes it.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int WORD_BYTES_DEF = 8;
    localparam int DUMP_WORDS_DEF = 64;

    // The pointer is at least one bit wide so that a single-word dump still has a register.
    function automatic int ptr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/dm_dump_counter.sv
// Dump word pointer: clears to 0, increments when enabled, holds at DUMP_WORDS-1 (no wrap).
// Zero latency on last (decoded from the register); no backpressure.
module dm_dump_counter
    import dm_arb_pkg::*;
#(
    parameter int DUMP_WORDS = DUMP_WORDS_DEF,
    localparam int PW        = ptr_width(DUMP_WORDS)
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [PW-1:0] ptr,
    output logic          last
);

    assign last = (ptr == PW'(DUMP_WORDS - 1));

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en && !last) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dm_dump_arbiter.sv
// Shares the data-memory port between the MEM stage and a dump sequencer that streams DUMP_WORDS words.
// Dump starts two cycles after a dump rise; the CPU is stalled DUMP_WORDS+1 cycles, the stream cannot be backpressured.
module dm_dump_arbiter
    import dm_arb_pkg::*;
#(
    parameter int N          = 64,
    parameter int DUMP_WORDS = DUMP_WORDS_DEF,
    parameter int WORD_BYTES = WORD_BYTES_DEF
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         cpu_memRead,
    input  logic         cpu_memWrite,
    input  logic [N-1:0] cpu_addr,
    input  logic [N-1:0] cpu_writeData,
    output logic [N-1:0] cpu_readData,
    output logic         cpu_stall,
    input  logic         dump,
    output logic         dump_valid,
    output logic [N-1:0] dump_addr,
    output logic [N-1:0] dump_data,
    output logic         dump_done,
    output logic [N-1:0] DM_addr,
    output logic [N-1:0] DM_writeData,
    output logic         DM_writeEnable,
    input  logic [N-1:0] DM_readData
);

    localparam int PW = ptr_width(DUMP_WORDS);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          dump_q;
    logic          rise;
    logic          ptr_clr;
    logic          ptr_en;
    logic          ptr_last;
    logic [PW-1:0] ptr;
    logic [N-1:0]  ptr_addr;

    // Data memory reads are combinational, so the read strobe carries no information here.
    logic unused_mem_read;
    assign unused_mem_read = cpu_memRead;

    assign rise = dump & ~dump_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dump_q  <= dump;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = DRAIN;
            DRAIN:   state_d = DUMP;
            DUMP:    if (ptr_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pointer sits at 0 everywhere outside DUMP, so the first dump cycle always addresses word 0.
    assign ptr_clr = (state_q != DUMP);
    assign ptr_en  = (state_q == DUMP);

    dm_dump_counter #(
        .DUMP_WORDS (DUMP_WORDS)
    ) u_counter (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clr      (ptr_clr),
        .en       (ptr_en),
        .ptr      (ptr),
        .last     (ptr_last)
    );

    assign ptr_addr = N'(ptr) * N'(WORD_BYTES);

    assign cpu_stall  = (state_q == DRAIN) || (state_q == DUMP);
    assign dump_valid = (state_q == DUMP);
    assign dump_done  = (state_q == DONE);

    always_comb begin
        DM_addr        = cpu_addr;
        DM_writeData   = cpu_writeData;
        DM_writeEnable = cpu_memWrite;
        cpu_readData   = DM_readData;
        dump_addr      = '0;
        dump_data      = '0;
        case (state_q)
            DRAIN: begin
                DM_writeEnable = 1'b0;
            end
            DUMP: begin
                DM_addr        = ptr_addr;
                DM_writeData   = '0;
                DM_writeEnable = 1'b0;
                cpu_readData   = '0;
                dump_addr      = ptr_addr;
                dump_data      = DM_readData;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_dump_arbiter.sv
// Scoreboard bench for dm_dump_arbiter with a combinational-read data memory model.
module tb_dm_dump_arbiter;

    localparam int N  = 64;
    localparam int DW = 64;
    localparam int WB = 8;

    logic         CLOCK_50 = 1'b0;
    logic         reset = 1'b0;
    logic         cpu_memRead = 1'b0;
    logic         cpu_memWrite = 1'b0;
    logic [N-1:0] cpu_addr = '0;
    logic [N-1:0] cpu_writeData = '0;
    logic [N-1:0] cpu_readData;
    logic         cpu_stall;
    logic         dump = 1'b0;
    logic         dump_valid;
    logic [N-1:0] dump_addr;
    logic [N-1:0] dump_data;
    logic         dump_done;
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic [N-1:0] DM_readData;

    dm_dump_arbiter #(
        .N          (N),
        .DUMP_WORDS (DW),
        .WORD_BYTES (WB)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .cpu_memRead    (cpu_memRead),
        .cpu_memWrite   (cpu_memWrite),
        .cpu_addr       (cpu_addr),
        .cpu_writeData  (cpu_writeData),
        .cpu_readData   (cpu_readData),
        .cpu_stall      (cpu_stall),
        .dump           (dump),
        .dump_valid     (dump_valid),
        .dump_addr      (dump_addr),
        .dump_data      (dump_data),
        .dump_done      (dump_done),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .DM_readData    (DM_readData)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [63:0] mem [0:127];
    logic [6:0]  widx;
    logic        preload = 1'b0;

    assign widx        = 7'(DM_addr >> 3);
    assign DM_readData = mem[widx];

    always @(posedge CLOCK_50) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= 64'(i * 3);
        end else if (DM_writeEnable) begin
            mem[widx] <= DM_writeData;
        end
    end

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] gold [0:DW-1];

    int total = 0;
    int bad = 0;
    int n_stall = 0;
    int n_valid = 0;
    int n_done = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (reset) begin
            if (cpu_stall) n_stall++;
            if (dump_done) n_done++;
            if (cpu_stall && cpu_memWrite) chk("wr_gate", 64'(DM_writeEnable), 64'd0);
            if (dump_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dump_addr", dump_addr, mon_e.addr);
                    chk("dump_data", dump_data, mon_e.data);
                    chk("dm_addr", DM_addr, mon_e.addr);
                    chk("rd_gate", cpu_readData, 64'd0);
                end
            end
        end
    end

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < DW; i++) begin
            e.addr = 64'(i * WB);
            e.data = gold[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, 64'(cpu_stall), 64'd0);
        chk({tag, "_valid"}, 64'(dump_valid), 64'd0);
        chk({tag, "_done"}, 64'(dump_done), 64'd0);
        chk({tag, "_we"}, 64'(DM_writeEnable), 64'd0);
        chk({tag, "_daddr"}, dump_addr, 64'd0);
        chk({tag, "_ddata"}, dump_data, 64'd0);
    endtask

    // Raises dump and follows one full stream; the monitor checks every word against the queue.
    task automatic do_dump(input string tag, input bit gate, input bit st0);
        int s0, v0, d0, lat;
        bit seen;
        s0 = n_stall;
        v0 = n_valid;
        d0 = n_done;
        if (st0) begin
            gold[0]       = 64'h55;
            cpu_memWrite  = 1'b1;
            cpu_addr      = 64'h0;
            cpu_writeData = 64'h55;
        end
        push_expected();
        dump = 1'b1;
        @(posedge CLOCK_50);
        #1;
        cpu_memWrite = 1'b0;
        if (gate) begin
            cpu_memWrite  = 1'b1;
            cpu_addr      = 64'h20;
            cpu_writeData = 64'hFFFF;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge CLOCK_50);
            #1;
            lat++;
            if (dump_done) seen = 1'b1;
        end
        cpu_memWrite = 1'b0;
        chk({tag, "_done_lat"}, 64'(lat), 64'(DW + 2));
        chk({tag, "_stall_cyc"}, 64'(n_stall - s0), 64'(DW + 1));
        chk({tag, "_words"}, 64'(n_valid - v0), 64'(DW));
        chk({tag, "_done_cnt"}, 64'(n_done - d0), 64'd1);
        chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int s0, v0, d0;
        for (int i = 0; i < DW; i++) gold[i] = 64'(i * 3);

        preload = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        preload = 1'b0;
        @(negedge CLOCK_50);
        check_reset_outputs("rst");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;

        cpu_memWrite  = 1'b1;
        cpu_memRead   = 1'b1;
        cpu_addr      = 64'h10;
        cpu_writeData = 64'hDEAD;
        @(negedge CLOCK_50);
        chk("pt_we", 64'(DM_writeEnable), 64'd1);
        chk("pt_addr", DM_addr, 64'h10);
        chk("pt_wdata", DM_writeData, 64'hDEAD);
        chk("pt_stall", 64'(cpu_stall), 64'd0);
        chk("pt_rdata", cpu_readData, 64'd6);
        #1;
        cpu_memWrite = 1'b0;
        cpu_memRead  = 1'b0;
        @(posedge CLOCK_50);
        #1;

        do_dump("full", 1'b0, 1'b0);
        s0 = n_stall;
        v0 = n_valid;
        repeat (10) @(posedge CLOCK_50);
        #1;
        chk("hold_stall", 64'(n_stall - s0), 64'd0);
        chk("hold_words", 64'(n_valid - v0), 64'd0);
        dump = 1'b0;
        @(posedge CLOCK_50);
        #1;

        do_dump("gate", 1'b1, 1'b0);
        chk("gate_mem4", mem[4], 64'd12);
        dump = 1'b0;
        @(posedge CLOCK_50);
        #1;

        do_dump("store", 1'b0, 1'b1);
        chk("store_mem0", mem[0], 64'h55);
        dump = 1'b0;
        @(posedge CLOCK_50);
        #1;

        v0 = n_valid;
        push_expected();
        dump = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLOCK_50);
            #1;
            if (n_valid - v0 >= 10) break;
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        chk("mid_rst_words", 64'(n_valid - v0), 64'd10);
        exp_q.delete();
        dump = 1'b0;
        d0 = n_done;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("mid_rst_no_done", 64'(n_done - d0), 64'd0);
        chk("mid_rst_stall_rel", 64'(cpu_stall), 64'd0);

        do_dump("after_rst", 1'b0, 1'b0);
        dump = 1'b0;
        @(posedge CLOCK_50);
        #1;
        do_dump("rearm", 1'b0, 1'b0);
        dump = 1'b0;
        @(posedge CLOCK_50);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
